// File: rtl/opcode_sequencer_if.sv
// Opcode sequencer bus bundle.
//   Command channel : cmd_valid, cmd_prog (controller -> sequencer), cmd_ready (back)
//   Opcode channel  : op_valid, op_data, op_last (sequencer -> datapath), op_ready (back)
//   Control/status  : abort (in), busy, done, err (out)
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid and ready are both high; once valid is raised the payload holds steady
// until that transfer, and ready may be driven independently of valid.
// Modport master is the controller/datapath side, slave is the sequencer.
interface opcode_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int PROG_W = 4
);
  logic              cmd_valid;
  logic [PROG_W-1:0] cmd_prog;
  logic              cmd_ready;
  logic              abort;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_data;
  logic              op_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmd_valid, cmd_prog, abort, op_ready,
    input  cmd_ready, op_valid, op_data, op_last, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_prog, abort, op_ready,
    output cmd_ready, op_valid, op_data, op_last, busy, done, err
  );
endinterface

// File: rtl/opcode_sequencer.sv
// Microcode sequencer: a command picks one of NUM_PROG programs and the block
// streams that program's opcodes out of a ROM, one per cycle, under valid/ready.
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        opcode_sequencer_if.slave (command, opcode stream, abort, status)
//   dbg_state  current FSM state (IDLE=0, FETCH=1, ISSUE=2, DONE=3)
// ROM_INIT holds one {last, opcode} word per ROM entry; TBL_INIT holds one
// {valid, start_addr} word per program slot. Both are elaboration-time images.
// A word at ROM_DEPTH-1 always ends the program; if its stored last bit was
// clear this is reported as an overrun through err alongside done.
module opcode_sequencer #(
  parameter int DATA_W    = 32,
  parameter int ROM_DEPTH = 64,
  parameter int NUM_PROG  = 16,
  parameter logic [DATA_W:0] ROM_INIT [ROM_DEPTH] = '{default: '0},
  parameter logic [$clog2(ROM_DEPTH):0] TBL_INIT [NUM_PROG] = '{default: '0}
) (
  input  logic                clk,
  input  logic                rst,
  opcode_sequencer_if.slave   bus,
  output logic [1:0]          dbg_state
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ROM_AW-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;
  logic              ovr_q;
  logic              err_q, err_d;
  logic              live_q;
  logic              start, load;
  logic [ROM_AW:0]   tbl_entry;
  logic              prog_ok;
  logic [DATA_W:0]   rom_word;
  logic              at_end;

  // Table lookup guarded so out-of-range indices never touch the image.
  always_comb begin
    tbl_entry = '0;
    if (32'(bus.cmd_prog) < NUM_PROG) tbl_entry = TBL_INIT[bus.cmd_prog];
  end
  assign prog_ok = tbl_entry[ROM_AW];

  assign rom_word = ROM_INIT[addr_q];
  assign at_end   = (addr_q == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Abort overrides every state; it also suppresses loads and any err pulse.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    load    = 1'b0;
    err_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            if (prog_ok) begin
              start   = 1'b1;
              state_d = FETCH;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        FETCH: begin
          load    = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: begin
          if (bus.op_ready) begin
            if (last_q) begin
              state_d = DONE;
              err_d   = ovr_q;
            end else begin
              load = 1'b1;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // The opcode register is reloaded on the same edge as each handshake, so the
  // next opcode is presented with no bubble. The address saturates at the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      ovr_q  <= 1'b0;
      err_q  <= 1'b0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      err_q  <= err_d;
      if (start) begin
        addr_q <= tbl_entry[ROM_AW-1:0];
      end else if (load) begin
        data_q <= rom_word[DATA_W-1:0];
        last_q <= rom_word[DATA_W] | at_end;
        ovr_q  <= at_end & ~rom_word[DATA_W];
        if (!at_end) addr_q <= addr_q + ROM_AW'(1);
      end
    end
  end

  // live_q keeps cmd_ready low until the first edge after reset release.
  assign bus.cmd_ready = live_q && (state_q == IDLE);
  assign bus.op_valid  = (state_q == ISSUE);
  assign bus.op_data   = data_q;
  assign bus.op_last   = last_q;
  assign bus.busy      = (state_q == FETCH) || (state_q == ISSUE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign dbg_state     = state_q;
endmodule
